// File: rtl/fifo_uart_tx.sv
// Drain stage for the byte FIFO: pops one word per frame from a first-word-fall-through FIFO
// and serialises it as a UART frame (start, LSB-first data, optional parity, stop bits).
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 234,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_read_en_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic                    tx_q, tx_d;
  logic                    rd_en_q, rd_en_d;
  logic                    bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      rd_en_q  <= rd_en_d;
    end
  end

  // tx is registered from the next-state decision, so the line changes on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    rd_en_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (enable_i && !fifo_empty_i) begin
          shift_d  = fifo_data_i;
          parity_d = (PARITY == 1) ? ~^fifo_data_i : ^fifo_data_i;
          rd_en_d  = 1'b1;
          tx_d     = 1'b0;
          state_d  = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (HAS_PARITY) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign fifo_read_en_o = rd_en_q;
  assign tx_o           = tx_q;
  assign busy_o         = (state_q != S_IDLE);
  assign frame_done_o   = (state_q == S_STOP) && bit_end && (idx_q == STOP_LAST);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: FWFT FIFO model on the read side, per-bit frame checks.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       rd_en, tx, busy, fdone;

  logic       p_en, p_empty;
  logic [7:0] p_data;
  logic       rd_e, tx_e, busy_e, fd_e;
  logic       rd_o, tx_od, busy_o, fd_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut (
    .clock_i(clk), .reset_ni(rst_n), .enable_i(en), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_read_en_o(rd_en), .tx_o(tx), .busy_o(busy),
    .frame_done_o(fdone)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut_even (
    .clock_i(clk), .reset_ni(rst_n), .enable_i(p_en), .fifo_empty_i(p_empty),
    .fifo_data_i(p_data), .fifo_read_en_o(rd_e), .tx_o(tx_e), .busy_o(busy_e),
    .frame_done_o(fd_e)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) dut_odd (
    .clock_i(clk), .reset_ni(rst_n), .enable_i(p_en), .fifo_empty_i(p_empty),
    .fifo_data_i(p_data), .fifo_read_en_o(rd_o), .tx_o(tx_od), .busy_o(busy_o),
    .frame_done_o(fd_o)
  );

  // FWFT FIFO: head word visible while non-empty, pop on a rising edge of read_en.
  logic [7:0] mem [0:15];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pops = 0;
  logic       rd_prev = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    rd_prev <= rd_en;
    if (rd_en === 1'b1 && rd_prev !== 1'b1 && rd_ptr != wr_ptr) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(output int idle);
    bit found;
    idle  = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1;
      else idle++;
    end
    if (!found) chk("start_timeout", 32'd0, 32'd1);
  endtask

  // Called on the first START cycle; checks the full 10-bit frame and its side signals.
  task automatic send_check(input logic [7:0] b, input int drop_at);
    logic [9:0] exp_bits;
    logic [3:0] samp;
    int rd_n, rd_at, fd_n, fd_at, nbusy, cyc;
    exp_bits = {1'b1, b, 1'b0};
    rd_n = 0; rd_at = -1; fd_n = 0; fd_at = -1; nbusy = 0;
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < CPB; c++) begin
        cyc = bi * CPB + c;
        if (cyc > 0) @(negedge clk);
        if (cyc == drop_at) en = 1'b0;
        samp[c] = tx;
        if (rd_en === 1'b1) begin rd_n++; rd_at = cyc; end
        if (fdone === 1'b1) begin fd_n++; fd_at = cyc; end
        if (busy !== 1'b1) nbusy++;
      end
      chk($sformatf("%02h_bit%0d", b, bi), 32'(samp), 32'({4{exp_bits[bi]}}));
    end
    chk($sformatf("%02h_rd_pulses", b), rd_n, 1);
    chk($sformatf("%02h_rd_cycle", b), rd_at, 0);
    chk($sformatf("%02h_done_pulses", b), fd_n, 1);
    chk($sformatf("%02h_done_cycle", b), fd_at, 10 * CPB - 1);
    chk($sformatf("%02h_busy_low", b), nbusy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle, p0, bad_rd, bad_tx, bad_busy, rd_e_n, rd_o_n, fde_at, fdo_at;
    bit found;
    logic [11:0] exp_e, exp_o;
    logic [3:0]  se, so;

    rst_n = 1'b1; en = 1'b0; p_en = 1'b0; p_empty = 1'b1; p_data = 8'h07;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_done", fdone, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Empty FIFO with enable high: nothing moves.
    en = 1'b1;
    bad_rd = 0; bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_en !== 1'b0) bad_rd++;
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("empty_rd_en", bad_rd, 0);
    chk("empty_tx", bad_tx, 0);
    chk("empty_busy", bad_busy, 0);

    // Single byte, tx falls on the first edge after the push.
    p0 = pops;
    push(8'hA5);
    wait_start(idle);
    chk("a5_latency", idle, 0);
    send_check(8'hA5, -1);
    chk("a5_pops", pops - p0, 1);

    // Back-to-back frames with a one-cycle idle gap.
    push(8'h00);
    push(8'hFF);
    p0 = pops;
    wait_start(idle);
    send_check(8'h00, -1);
    wait_start(idle);
    chk("b2b_gap", idle, 1);
    send_check(8'hFF, -1);
    chk("b2b_pops", pops - p0, 2);
    chk("b2b_empty", fifo_empty, 1'b1);

    // Enable drops mid-frame: frame finishes, then no further pops until re-enabled.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    p0 = pops;
    wait_start(idle);
    send_check(8'h11, 10);
    bad_rd = 0; bad_tx = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_en !== 1'b0) bad_rd++;
      if (tx !== 1'b1) bad_tx++;
    end
    chk("gate_rd_en", bad_rd, 0);
    chk("gate_tx", bad_tx, 0);
    chk("gate_pops", pops - p0, 1);
    en = 1'b1;
    wait_start(idle);
    send_check(8'h22, -1);
    wait_start(idle);
    chk("gate_gap", idle, 1);
    send_check(8'h33, -1);
    chk("gate_pops_all", pops - p0, 3);

    // Reset during data bit 3 of 0x3C: line returns high at once, 0x3C is lost.
    push(8'h3C);
    push(8'h5A);
    p0 = pops;
    wait_start(idle);
    repeat (17) @(negedge clk);
    chk("3c_bit3_tx", tx, 1'b1);
    chk("3c_bit3_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rd_en", rd_en, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_start(idle);
    send_check(8'h5A, -1);
    chk("midrst_pops", pops - p0, 2);

    // Parity + two stop bits on 0x07: even parity 1, odd parity 0.
    exp_e = {2'b11, 1'b1, 8'h07, 1'b0};
    exp_o = {2'b11, 1'b0, 8'h07, 1'b0};
    p_en = 1'b1;
    p_empty = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (tx_e === 1'b0) found = 1;
    end
    chk("par_start_seen", 32'(found), 1);
    p_empty = 1'b1;
    p_en = 1'b0;
    rd_e_n = 0; rd_o_n = 0; fde_at = -1; fdo_at = -1;
    for (int bi = 0; bi < 12; bi++) begin
      for (int c = 0; c < CPB; c++) begin
        if (bi * CPB + c > 0) @(negedge clk);
        se[c] = tx_e;
        so[c] = tx_od;
        if (rd_e === 1'b1) rd_e_n++;
        if (rd_o === 1'b1) rd_o_n++;
        if (fd_e === 1'b1) fde_at = bi * CPB + c;
        if (fd_o === 1'b1) fdo_at = bi * CPB + c;
      end
      chk($sformatf("even_bit%0d", bi), 32'(se), 32'({4{exp_e[bi]}}));
      chk($sformatf("odd_bit%0d", bi), 32'(so), 32'({4{exp_o[bi]}}));
    end
    chk("even_rd_pulses", rd_e_n, 1);
    chk("odd_rd_pulses", rd_o_n, 1);
    chk("even_done_cycle", fde_at, 12 * CPB - 1);
    chk("odd_done_cycle", fdo_at, 12 * CPB - 1);
    @(negedge clk);
    chk("even_idle_busy", busy_e, 1'b0);
    chk("odd_idle_tx", tx_od, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
